// File: rtl/insn_fetch.sv
// Instruction fetch stage: holds the current 64-bit word and half select for the
// decoder, demand-fetches on redirect and prefetches the next word into a 1-deep buffer.
module insn_fetch #(
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          jump,
  input  logic [AW-1:0] jump_addr,
  input  logic          jump_right,
  input  logic          next,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [63:0]   mem_rdata,
  output logic [63:0]   word,
  output logic          tkk,
  output logic          valid,
  output logic [AW-1:0] pc
);

  typedef enum logic [1:0] {IDLE, FETCH, RUN} state_t;

  state_t        state;
  logic          pf_full;
  logic          discard;
  logic [63:0]   pf_buf;
  logic          ack;
  logic          advance;
  logic [AW-1:0] pc_inc;

  assign ack     = mem_req & mem_ack;
  assign advance = next & tkk;
  assign pc_inc  = pc + AW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      word     <= '0;
      tkk      <= 1'b0;
      valid    <= 1'b0;
      pc       <= '0;
      pf_full  <= 1'b0;
      pf_buf   <= '0;
      discard  <= 1'b0;
    end else if (jump) begin
      pc      <= jump_addr;
      tkk     <= jump_right;
      valid   <= 1'b0;
      pf_full <= 1'b0;
      state   <= FETCH;
      // A request still in flight cannot be withdrawn; mark it stale instead.
      if (mem_req && !mem_ack) begin
        discard <= 1'b1;
      end else begin
        discard  <= 1'b0;
        mem_req  <= 1'b1;
        mem_addr <= jump_addr;
      end
    end else if (ack && discard) begin
      discard  <= 1'b0;
      mem_addr <= pc;
    end else begin
      case (state)
        IDLE: ;
        FETCH: begin
          if (ack) begin
            word    <= mem_rdata;
            valid   <= 1'b1;
            mem_req <= 1'b0;
            state   <= RUN;
          end else if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end
        end
        RUN: begin
          if (next) tkk <= ~tkk;
          if (advance) begin
            pc <= pc_inc;
            if (pf_full) begin
              word    <= pf_buf;
              pf_full <= 1'b0;
            end else if (ack) begin
              word    <= mem_rdata;
              mem_req <= 1'b0;
            end else begin
              // Any in-flight prefetch already targets pc+1 and becomes the demand fetch.
              valid <= 1'b0;
              state <= FETCH;
              if (!mem_req) begin
                mem_req  <= 1'b1;
                mem_addr <= pc_inc;
              end
            end
          end else if (ack) begin
            pf_buf  <= mem_rdata;
            pf_full <= 1'b1;
            mem_req <= 1'b0;
          end else if (!pf_full && !mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= pc_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: directed scenarios with literal expectations, then random
// jump/next/ack traffic checked every cycle against a queue-based fetch model.
module tb_insn_fetch;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          jump = 1'b0, jump_right = 1'b0, next = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic [63:0]   mem_rdata = '0;
  logic          mem_req, tkk, valid;
  logic [AW-1:0] mem_addr, pc;
  logic [63:0]   word;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model: the word being decoded, a queue holding the prefetched word, and the
  // single in-flight request (address + whether its data is still wanted).
  bit            m_have;
  bit            m_valid, m_half, m_req, m_stale;
  logic [AW-1:0] m_pc, m_addr;
  logic [63:0]   m_word;
  logic [63:0]   m_buf[$];

  always #5 clk = ~clk;

  insn_fetch #(.AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .jump(jump), .jump_addr(jump_addr),
    .jump_right(jump_right), .next(next), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .word(word), .tkk(tkk),
    .valid(valid), .pc(pc)
  );

  function automatic logic [63:0] memfn(input logic [AW-1:0] a);
    if (a == 20'h00100) return 64'h0123_4567_89ab_cdef;
    return {12'hA5A, a, 12'h5A5, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_valid = 0; m_half = 0; m_req = 0; m_stale = 0;
    m_pc = '0; m_addr = '0; m_word = '0;
    m_buf.delete();
  endtask

  task automatic model_update(input bit j, input logic [AW-1:0] ja, input bit jr,
                              input bit nx, input bit ak, input logic [63:0] rd);
    bit acked;
    acked = m_req && ak;
    if (j) begin
      m_pc = ja; m_half = jr; m_valid = 0; m_have = 1;
      m_buf.delete();
      if (m_req && !acked) m_stale = 1;
      else begin m_req = 1; m_addr = ja; m_stale = 0; end
    end else if (acked && m_stale) begin
      m_stale = 0; m_req = 1; m_addr = m_pc;
    end else if (m_have && !m_valid) begin
      if (acked) begin m_word = rd; m_valid = 1; m_req = 0; end
      else if (!m_req) begin m_req = 1; m_addr = m_pc; end
    end else if (m_have) begin
      if (nx && m_half) begin
        m_pc = m_pc + 20'd1; m_half = 0;
        if (m_buf.size() != 0) m_word = m_buf.pop_front();
        else if (acked) begin m_word = rd; m_req = 0; end
        else begin
          m_valid = 0;
          if (!m_req) begin m_req = 1; m_addr = m_pc; end
        end
      end else begin
        if (nx) m_half = 1;
        if (acked) begin m_buf.push_back(rd); m_req = 0; end
        else if (m_buf.size() == 0 && !m_req) begin m_req = 1; m_addr = m_pc + 20'd1; end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req", 64'(mem_req), 64'(m_req));
      if (m_req) chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("valid", 64'(valid), 64'(m_valid));
      chk("pc", 64'(pc), 64'(m_pc));
      chk("tkk", 64'(tkk), 64'(m_half));
      if (m_valid) chk("word", word, m_word);
    end
  end

  // Drive one cycle of inputs just after a falling edge; ack only a live request.
  task automatic step(input bit j, input logic [AW-1:0] ja, input bit jr,
                      input bit nx, input bit ak);
    jump = j; jump_addr = ja; jump_right = jr; next = nx;
    mem_ack = ak && m_req;
    mem_rdata = mem_ack ? memfn(m_addr) : {$urandom, $urandom};
    @(posedge clk);
    model_update(j, ja, jr, nx, mem_ack, mem_rdata);
    @(negedge clk);
  endtask

  initial begin
    logic [AW-1:0] ra;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_word", word, 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    reset_n = 1'b1;
    chk_en = 1'b1;

    step(0, '0, 0, 1, 1);
    chk("idle_next_req", 64'(mem_req), 64'd0);

    // jump, request next cycle, ack two cycles later, word live the cycle after
    step(1, 20'h00100, 0, 0, 0);
    chk("t1_req", 64'(mem_req), 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'h00100);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 1);
    chk("t1_valid", 64'(valid), 64'd1);
    chk("t1_pc", 64'(pc), 64'h00100);
    chk("t1_word", word, 64'h0123_4567_89ab_cdef);

    step(0, '0, 0, 0, 0);
    chk("t2_pf_addr", 64'(mem_addr), 64'h00101);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 1, 0);
    chk("t2_tkk1", 64'(tkk), 64'd1);
    chk("t2_pc_same", 64'(pc), 64'h00100);
    step(0, '0, 0, 1, 0);
    chk("t2_pc_adv", 64'(pc), 64'h00101);
    chk("t2_valid", 64'(valid), 64'd1);
    chk("t2_word", word, 64'hA5A0_0101_5A50_0101);

    // redirect while prefetch of 0x102 is in flight
    step(0, '0, 0, 0, 0);
    chk("t4_pf_addr", 64'(mem_addr), 64'h00102);
    step(1, 20'h00300, 0, 0, 0);
    chk("t4_hold_addr", 64'(mem_addr), 64'h00102);
    chk("t4_valid0", 64'(valid), 64'd0);
    step(0, '0, 0, 0, 0);
    chk("t4_hold_addr2", 64'(mem_addr), 64'h00102);
    step(0, '0, 0, 0, 1);
    chk("t4_new_req", 64'(mem_req), 64'd1);
    chk("t4_new_addr", 64'(mem_addr), 64'h00300);
    chk("t4_still0", 64'(valid), 64'd0);
    step(0, '0, 0, 0, 1);
    chk("t4_pc", 64'(pc), 64'h00300);

    step(1, 20'h00200, 1, 0, 0);
    step(0, '0, 0, 0, 1);
    chk("t3_tkk", 64'(tkk), 64'd1);
    step(0, '0, 0, 1, 0);
    chk("t3_pc", 64'(pc), 64'h00201);
    chk("t3_tkk0", 64'(tkk), 64'd0);
    step(0, '0, 0, 0, 1);

    // jump wins over next in the same cycle; next ignored while not valid
    step(1, 20'h00400, 1, 1, 0);
    chk("t6_jpc", 64'(pc), 64'h00400);
    chk("t6_jtkk", 64'(tkk), 64'd1);
    step(0, '0, 0, 1, 0);
    chk("t6_ign_pc", 64'(pc), 64'h00400);
    chk("t6_ign_tkk", 64'(tkk), 64'd1);
    step(0, '0, 0, 0, 1);

    step(1, 20'hFFFFF, 0, 0, 0);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 0);
    chk("t5_wrap_addr", 64'(mem_addr), 64'h00000);
    chk("t5_wrap_req", 64'(mem_req), 64'd1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    chk("t5_pc0", 64'(pc), 64'h00000);
    chk("t5_word", word, 64'hA5A0_0000_5A50_0000);

    // asynchronous reset in the middle of an outstanding request
    step(0, '0, 0, 0, 0);
    #2 reset_n = 1'b0;
    chk_en = 1'b0;
    #1;
    chk("t6_rst_req", 64'(mem_req), 64'd0);
    chk("t6_rst_valid", 64'(valid), 64'd0);
    chk("t6_rst_pc", 64'(pc), 64'd0);
    chk("t6_rst_word", word, 64'd0);
    chk("t6_rst_addr", 64'(mem_addr), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 20'hFFFFF - AW'($urandom_range(0, 2)) : AW'($urandom);
      step($urandom_range(0, 15) == 0, ra, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
